mem_burst_responder: RTL and testbench
======================================

// Module: mem_burst_responder
// PURPOSE
//  Memory-side end of the cache/memory burst bus: accepts a strobe from the cache controller, returns
//  MGrant, then streams a fixed-length read burst (mSDR_RxD) or sinks a write burst (mSDR_TxD).
//  Backs an on-chip word RAM; sits between the data-cache controller and the board memory map.
// PARAMETERS
//  DATA_W     32  data bus width (bits)
//  ADDR_W     10  word-address width of backing RAM (depth 2**ADDR_W)
//  BURST_LEN   4  beats per burst; legal 1..7 (3-bit beat counter on the cache side)
//  RD_LAT      2  cycles from grant to first read beat (>=1)
//  WR_LAT      1  cycles from grant to first write beat (>=1)
//  REF_INTERVAL 64 cycles between refresh requests (MEM_REFRESH_EN only)
//  REF_CYCLES  4  cycles bus is blocked per refresh (MEM_REFRESH_EN only)
// PORTS
//  Clk       in   1       clock, all state on rising edge
//  Reset     in   1       asynchronous, active-high reset
//  MStrobe   in   1       cache transaction request (level, held until MGrant)
//  MRW       in   1       1 = read burst, 0 = write burst; sampled with MStrobe at accept
//  MAddress  in   ADDR_W  word address; low clog2(BURST_LEN) bits ignored (burst-aligned)
//  MDataIn   in   DATA_W  write data from cache, valid on every mSDR_TxD cycle
//  MDataOut  out  DATA_W  read data to cache, valid on every mSDR_RxD cycle
//  MGrant    out  1       bus granted; high from accept through DONE
//  mSDR_RxD  out  1       read beat valid (cache fills one beat per high cycle)
//  mSDR_TxD  out  1       write beat strobe (responder captures MDataIn)
//  Busy      out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: State=IDLE, beat counter=0, latency counter=0, MGrant/mSDR_RxD/mSDR_TxD/Busy=0, MDataOut=0;
//   RAM contents untouched. Reset mid-burst aborts immediately; no partial-state recovery.
//  States: IDLE, GRANT, RLAT, RBURST, WLAT, WBURST, DONE (REFRESH with MEM_REFRESH_EN).
//  IDLE: MStrobe=1 -> GRANT; latch base=MAddress with low bits cleared, latch MRW.
//  GRANT: MGrant=1 (registered, so visible 1 cycle after strobe seen). Next: MRW ? RLAT : WLAT.
//  RLAT: wait RD_LAT-1 cycles (0 wait if RD_LAT=1) -> RBURST. WLAT likewise with WR_LAT -> WBURST.
//  RBURST: mSDR_RxD=1 exactly BURST_LEN consecutive cycles; MDataOut=mem[base+beat], beat 0..BURST_LEN-1
//   (ascending, LSB word first, matching cache fill order). Last beat -> DONE.
//  WBURST: mSDR_TxD=1 exactly BURST_LEN consecutive cycles; mem[base+beat]<=MDataIn each cycle. -> DONE.
//  DONE: RxD/TxD=0, MGrant held 1 so the cache sees strobe low with count==BURST_LEN; next -> IDLE,
//   MGrant=0. Beat/latency counters cleared.
//  Strobe gaps: MStrobe ignored in all states but IDLE; new request accepted earliest the cycle after
//   DONE (min 2 idle-to-idle turnaround: one IDLE cycle between bursts).
//  Address: base+beat computed in ADDR_W bits; burst never crosses an aligned block, so no wrap;
//   MAddress top-of-RAM block is legal.
//  RxD and TxD are never high together; MGrant is high whenever either is high.
//  MDataOut holds last beat value outside RBURST (not re-zeroed).
// CONFIGURATION
//  MEM_REFRESH_EN defined: free-running counter raises refresh-pending every REF_INTERVAL cycles.
//   In IDLE, pending refresh wins over a simultaneous MStrobe: -> REFRESH for REF_CYCLES cycles
//   (Busy=1, MGrant=0), then IDLE; strobe is then accepted. Refresh never preempts a burst; it
//   stays pending until IDLE. Counter resets to 0 on Reset.
//  MEM_REFRESH_EN undefined: no REFRESH state, no refresh counter; REF_* parameters unused.
// TESTING
//  Reset, preload mem[0x40..0x43]=A0..A3, MStrobe+MRW=1 @0x42 -> MGrant rises, RD_LAT later RxD high
//   4 cycles with A0,A1,A2,A3; DONE one cycle then MGrant=0.
//  Write burst @0x10, MDataIn=D0..D3 on TxD cycles -> TxD high 4 cycles; readback burst returns D0..D3.
//  MStrobe held high across whole read burst + extra pulse during RBURST -> ignored; exactly one burst.
//  Assert Reset on beat 2 of read burst -> all outputs 0 same cycle; RAM unchanged; next burst normal.
//  Back-to-back strobes (read then write) -> second grant one IDLE cycle after first DONE, no overlap.
//  MEM_REFRESH_EN, REF_INTERVAL=64: strobe on refresh-due cycle -> 4 REFRESH cycles, MGrant=0, then grant;
//   refresh due mid-burst -> deferred until burst's DONE->IDLE.

Source files
------------

// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - memory-side burst responder over an on-chip word RAM.
// Optional refresh blocking is compiled in with MEM_REFRESH_EN.
module mem_burst_responder #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int BURST_LEN    = 4,
  parameter int RD_LAT       = 2,
  parameter int WR_LAT       = 1,
  parameter int REF_INTERVAL = 64,
  parameter int REF_CYCLES   = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddress,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MGrant,
  output logic              mSDR_RxD,
  output logic              mSDR_TxD,
  output logic              Busy
);

  localparam int ALIGN = $clog2(BURST_LEN);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GRANT   = 3'd1;
  localparam logic [2:0] RLAT    = 3'd2;
  localparam logic [2:0] RBURST  = 3'd3;
  localparam logic [2:0] WLAT    = 3'd4;
  localparam logic [2:0] WBURST  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
`ifdef MEM_REFRESH_EN
  localparam logic [2:0] REFRESH = 3'd7;
`endif

  logic [2:0]        state, next_state;
  logic              rw;
  logic [ADDR_W-1:0] base, rd_addr, wr_addr;
  logic [2:0]        beat;
  logic [7:0]        lat;
  logic              ref_go, in_refresh, in_wait;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

`ifdef MEM_REFRESH_EN
  logic [$clog2(REF_INTERVAL)-1:0] ref_cnt;
  logic                            ref_pending;

  // Pending refresh is only consumed from IDLE, so a burst is never preempted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (state == IDLE && next_state == REFRESH)
        ref_pending <= 1'b0;
      if (ref_cnt == ($bits(ref_cnt))'(REF_INTERVAL-1)) begin
        ref_cnt     <= '0;
        ref_pending <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
    end
  end

  assign ref_go     = ref_pending;
  assign in_refresh = (state == REFRESH);
`else
  assign ref_go     = 1'b0;
  assign in_refresh = 1'b0;
`endif

  assign in_wait = (state == RLAT) || (state == WLAT) || in_refresh;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
`ifdef MEM_REFRESH_EN
        if (ref_go)       next_state = REFRESH;
        else if (MStrobe) next_state = GRANT;
`else
        if (MStrobe && !ref_go) next_state = GRANT;
`endif
      end
      GRANT: begin
        if (rw) next_state = (RD_LAT == 1) ? RBURST : RLAT;
        else    next_state = (WR_LAT == 1) ? WBURST : WLAT;
      end
      RLAT:    if (lat == 8'(RD_LAT-2)) next_state = RBURST;
      WLAT:    if (lat == 8'(WR_LAT-2)) next_state = WBURST;
      RBURST:  if (beat == 3'(BURST_LEN-1)) next_state = DONE;
      WBURST:  if (beat == 3'(BURST_LEN-1)) next_state = DONE;
      DONE:    next_state = IDLE;
`ifdef MEM_REFRESH_EN
      REFRESH: if (lat == 8'(REF_CYCLES-1)) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Read data is prefetched one cycle ahead so MDataOut is valid while RxD is high.
  assign rd_addr = (state == RBURST) ? base + ADDR_W'(beat) + ADDR_W'(1) : base;
  assign wr_addr = base + ADDR_W'(beat);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      rw       <= 1'b0;
      base     <= '0;
      beat     <= '0;
      lat      <= '0;
      MDataOut <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == GRANT) begin
        base <= (MAddress >> ALIGN) << ALIGN;
        rw   <= MRW;
      end
      if (next_state != state) lat <= '0;
      else if (in_wait)        lat <= lat + 1'b1;
      if (state == RBURST || state == WBURST) beat <= beat + 1'b1;
      else if (state == DONE)                 beat <= '0;
      if (next_state == RBURST) MDataOut <= mem[rd_addr];
    end
  end

  // RAM has no reset so its contents survive a Reset pulse.
  always_ff @(posedge Clk) begin
    if (state == WBURST) mem[wr_addr] <= MDataIn;
  end

  assign Busy     = (state != IDLE);
  assign MGrant   = Busy && !in_refresh;
  assign mSDR_RxD = (state == RBURST);
  assign mSDR_TxD = (state == WBURST);

endmodule

// File: tb/tb_mem_burst_responder.sv
// tb/tb_mem_burst_responder.sv - scoreboard bench for mem_burst_responder (default build).
module tb_mem_burst_responder;

  logic        Clk = 1'b0;
  logic        Reset, MStrobe, MRW;
  logic [9:0]  MAddress;
  logic [31:0] MDataIn, MDataOut;
  logic        MGrant, mSDR_RxD, mSDR_TxD, Busy;

  mem_burst_responder dut (
    .Clk(Clk), .Reset(Reset), .MStrobe(MStrobe), .MRW(MRW), .MAddress(MAddress),
    .MDataIn(MDataIn), .MDataOut(MDataOut), .MGrant(MGrant), .mSDR_RxD(mSDR_RxD),
    .mSDR_TxD(mSDR_TxD), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [31:0] model [0:1023];
  logic [31:0] exp_q[$];
  logic [31:0] wq[$];
  int grant_cyc, fall_cyc, first_beat_cyc, last_beat_cyc, nbeats;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One full burst; hold keeps MStrobe high (with a glitch) until DONE.
  task automatic burst(input logic rw, input logic [9:0] addr, input logic hold, input logic [31:0] seed);
    logic [9:0]  base;
    logic [31:0] w, e;
    logic        granted, finished;
    base = {addr[9:2], 2'b00};
    for (int b = 0; b < 4; b++) begin
      if (rw) exp_q.push_back(model[base + 10'(b)]);
      else begin
        w = seed + 32'(b);
        model[base + 10'(b)] = w;
        wq.push_back(w);
      end
    end
    MStrobe = 1'b1; MRW = rw; MAddress = addr;
    granted = 1'b0; finished = 1'b0; nbeats = 0;
    first_beat_cyc = 0; last_beat_cyc = 0;
    for (int i = 0; i < 40 && !finished; i++) begin
      step();
      if (!granted && MGrant) begin
        granted = 1'b1; grant_cyc = cyc;
        if (!hold) MStrobe = 1'b0;
      end
      if (mSDR_RxD || mSDR_TxD) begin
        if (nbeats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        nbeats++;
        checks++;
        if ((mSDR_RxD && mSDR_TxD) || !MGrant) begin
          errors++;
          $display("FAIL strobe_excl: rxd=%b txd=%b grant=%b, required one strobe with grant", mSDR_RxD, mSDR_TxD, MGrant);
        end
      end
      if (mSDR_RxD) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rdata_extra: got %h, required no beat", MDataOut);
        end else begin
          e = exp_q.pop_front();
          if (MDataOut !== e) begin
            errors++;
            $display("FAIL rdata @%h beat %0d: got %h, required %h", base, nbeats-1, MDataOut, e);
          end
        end
      end
      if (mSDR_TxD && wq.size() > 0) MDataIn = wq.pop_front();
      if (hold && granted) begin
        if (nbeats == 1) MStrobe = 1'b0;
        else if (nbeats == 2) MStrobe = 1'b1;
        else if (nbeats == 4 && !mSDR_RxD && !mSDR_TxD) MStrobe = 1'b0;
      end
      if (granted && !MGrant) begin
        finished = 1'b1; fall_cyc = cyc;
      end
    end
    MStrobe = 1'b0;
    checks++;
    if (!finished) begin errors++; $display("FAIL burst_timeout @%h: got no grant release, required release", addr); end
    checks++;
    if (nbeats != 4) begin errors++; $display("FAIL beat_count @%h: got %0d, required 4", addr, nbeats); end
    checks++;
    if (first_beat_cyc - grant_cyc != (rw ? 2 : 1)) begin
      errors++; $display("FAIL latency @%h: got %0d, required %0d", addr, first_beat_cyc - grant_cyc, rw ? 2 : 1);
    end
    checks++;
    if (fall_cyc != last_beat_cyc + 2) begin
      errors++; $display("FAIL done_len @%h: got %0d, required %0d", addr, fall_cyc - last_beat_cyc, 2);
    end
    checks++;
    if (exp_q.size() != 0 || wq.size() != 0) begin
      errors++; $display("FAIL leftover: got %0d/%0d, required 0/0", exp_q.size(), wq.size());
    end
    exp_q.delete(); wq.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1; MStrobe = 1'b0; MRW = 1'b0; MAddress = '0; MDataIn = '0;
    step(); step();
    checks++;
    if ({MGrant, mSDR_RxD, mSDR_TxD, Busy} !== 4'b0 || MDataOut !== 32'h0) begin
      errors++; $display("FAIL reset_outs: got %b/%h, required 0000/0", {MGrant, mSDR_RxD, mSDR_TxD, Busy}, MDataOut);
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_read();
    burst(1'b0, 10'h040, 1'b0, 32'hA000_00A0);
    step();
    burst(1'b1, 10'h042, 1'b0, 32'h0);
  endtask

  task automatic test_write_readback();
    burst(1'b0, 10'h011, 1'b0, 32'hD000_00D0);
    step();
    burst(1'b1, 10'h013, 1'b0, 32'h0);
    step();
    burst(1'b0, 10'h3FE, 1'b0, 32'hFACE_0000);
    step();
    burst(1'b1, 10'h3FC, 1'b0, 32'h0);
  endtask

  task automatic test_strobe_hold();
    int extra;
    step();
    burst(1'b1, 10'h040, 1'b1, 32'h0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (MGrant || Busy) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL strobe_ignored: got %0d busy cycles, required 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    int beats;
    logic hit;
    step();
    MStrobe = 1'b1; MRW = 1'b1; MAddress = 10'h040;
    beats = 0; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (MGrant) MStrobe = 1'b0;
      if (mSDR_RxD) begin
        e = model[10'h040 + 10'(beats)];
        checks++;
        if (MDataOut !== e) begin errors++; $display("FAIL rst_rdata beat %0d: got %h, required %h", beats, MDataOut, e); end
        if (beats == 2) begin
          hit = 1'b1;
          Reset = 1'b1;
          #1;
          checks++;
          if ({MGrant, mSDR_RxD, mSDR_TxD, Busy} !== 4'b0 || MDataOut !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got %b/%h, required 0000/0", {MGrant, mSDR_RxD, mSDR_TxD, Busy}, MDataOut);
          end
        end
        beats++;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_timeout: got %0d beats, required 3", beats); end
    MStrobe = 1'b0;
    step();
    Reset = 1'b0;
    step();
    burst(1'b1, 10'h041, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int first_fall;
    step();
    burst(1'b1, 10'h010, 1'b1, 32'h0);
    first_fall = fall_cyc;
    burst(1'b0, 10'h020, 1'b0, 32'h5EED_0000);
    checks++;
    if (grant_cyc != first_fall + 1) begin
      errors++; $display("FAIL b2b_gap: got grant %0d cycles after release, required 1", grant_cyc - first_fall);
    end
    step();
    burst(1'b1, 10'h022, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_readback();
    test_strobe_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
